// File: rtl/exe_unit_w12_core.sv
// Registered ALU slice for the W12 datapath: ADD, SUB, POPCOUNT, SHL with V/N/C/Z flags.
// Optional macro EXE_UNIT_W12_SATURATE_EN clamps ADD/SUB results on carry/borrow.
module exe_unit_w12_core #(
  parameter int M = 4,
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic [N-1:0] i_oper,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam logic [N-1:0] OP_ADD = N'(0);
  localparam logic [N-1:0] OP_SUB = N'(1);
  localparam logic [N-1:0] OP_POP = N'(2);
  localparam logic [N-1:0] OP_SHL = N'(3);
  localparam logic [M-1:0] M_VAL  = M'(M);

  logic [M:0]     sum_w;
  logic [M:0]     diff_w;
  logic           add_ovf;
  logic           sub_ovf;
  logic [M-1:0]   pop_cnt;
  logic [2*M-1:0] shl_wide;
  logic [M-1:0]   shl_res;
  logic           shl_carry;
  logic [M-1:0]   next_result;
  logic           next_v;
  logic           next_c;

  assign sum_w  = {1'b0, i_argA} + {1'b0, i_argB};
  assign diff_w = {1'b0, i_argA} - {1'b0, i_argB};

  // Signed overflow taken on the raw (unsaturated) result.
  assign add_ovf = (i_argA[M-1] == i_argB[M-1]) && (sum_w[M-1]  != i_argA[M-1]);
  assign sub_ovf = (i_argA[M-1] != i_argB[M-1]) && (diff_w[M-1] != i_argA[M-1]);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < M; i++) begin
      pop_cnt = pop_cnt + {{(M-1){1'b0}}, i_argA[i]};
    end
  end

  // Shift in a double-width window so the bits pushed out land in the upper half.
  always_comb begin
    shl_wide  = '0;
    shl_res   = '0;
    shl_carry = 1'b0;
    if (i_argB >= M_VAL) begin
      shl_carry = |i_argA;
    end else begin
      shl_wide  = {{M{1'b0}}, i_argA} << i_argB;
      shl_res   = shl_wide[M-1:0];
      shl_carry = |shl_wide[2*M-1:M];
    end
  end

  always_comb begin
    next_result = '0;
    next_v      = 1'b0;
    next_c      = 1'b0;
    case (i_oper)
      OP_ADD: begin
        next_c = sum_w[M];
        next_v = add_ovf;
`ifdef EXE_UNIT_W12_SATURATE_EN
        next_result = sum_w[M] ? {M{1'b1}} : sum_w[M-1:0];
`else
        next_result = sum_w[M-1:0];
`endif
      end
      OP_SUB: begin
        next_c = diff_w[M];
        next_v = sub_ovf;
`ifdef EXE_UNIT_W12_SATURATE_EN
        next_result = diff_w[M] ? '0 : diff_w[M-1:0];
`else
        next_result = diff_w[M-1:0];
`endif
      end
      OP_POP: begin
        next_result = pop_cnt;
      end
      OP_SHL: begin
        next_result = shl_res;
        next_c      = shl_carry;
      end
      default: begin
        next_result = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      o_result <= '0;
      o_status <= '0;
    end else begin
      o_result <= next_result;
      o_status <= {next_v, next_result[M-1], next_c, (next_result == '0)};
    end
  end

endmodule

// File: tb/tb_exe_unit_w12_core.sv
// Directed bench for exe_unit_w12_core (M=4, N=2) with a queue-based scoreboard.
module tb_exe_unit_w12_core;

  logic       clk;
  logic       rst_n;
  logic [1:0] oper;
  logic [3:0] arg_a;
  logic [3:0] arg_b;
  logic [3:0] result;
  logic [3:0] status;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         errors;

  exe_unit_w12_core #(.M(4), .N(2)) dut (
    .i_clk    (clk),
    .i_rsn    (rst_n),
    .i_oper   (oper),
    .i_argA   (arg_a),
    .i_argB   (arg_b),
    .o_result (result),
    .o_status (status)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: inputs change on the falling edge, expectation queued for the next rising edge
  task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp_r, input logic [3:0] exp_s, input string nm);
    @(negedge clk);
    oper  = op;
    arg_a = a;
    arg_b = b;
    exp_q.push_back({exp_r, exp_s});
    name_q.push_back(nm);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard not drained, %0d left, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic check_now(input string nm, input logic [3:0] exp_r, input logic [3:0] exp_s);
    checks++;
    if (result !== exp_r || status !== exp_s) begin
      errors++;
      $display("FAIL %s: got result=%b status=%b, required result=%b status=%b",
               nm, result, status, exp_r, exp_s);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [7:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({result, status} !== e) begin
          errors++;
          $display("FAIL %s: got result=%b status=%b, required result=%b status=%b",
                   nm, result, status, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    oper   = 2'd0;
    arg_a  = 4'd7;
    arg_b  = 4'd7;
    #12;
    check_now("reset_state", 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'd0, 4'd2, 4'd3, 4'd5, 4'b0000, "add_2_3");
    drive(2'd0, 4'd4, 4'd5, 4'd9, 4'b1100, "add_4_5");
`ifdef EXE_UNIT_W12_SATURATE_EN
    drive(2'd0, 4'd8, 4'd8, 4'd15, 4'b1110, "add_8_8_sat");
    drive(2'd0, 4'd15, 4'd1, 4'd15, 4'b0110, "add_15_1_sat");
`else
    drive(2'd0, 4'd8, 4'd8, 4'd0, 4'b1011, "add_8_8");
    drive(2'd0, 4'd15, 4'd1, 4'd0, 4'b0011, "add_15_1");
`endif
    drive(2'd1, 4'd5, 4'd3, 4'd2, 4'b0000, "sub_5_3");
    drive(2'd1, 4'd5, 4'd5, 4'd0, 4'b0001, "sub_5_5");
`ifdef EXE_UNIT_W12_SATURATE_EN
    drive(2'd1, 4'd2, 4'd3, 4'd0, 4'b0011, "sub_2_3_sat");
`else
    drive(2'd1, 4'd2, 4'd3, 4'd15, 4'b0110, "sub_2_3");
`endif
    drive(2'd1, 4'd8, 4'd1, 4'd7, 4'b1000, "sub_8_1");
    drive(2'd2, 4'b1001, 4'd6, 4'd2, 4'b0000, "pop_1001");
    drive(2'd2, 4'b1111, 4'd0, 4'd4, 4'b0000, "pop_1111");
    drive(2'd2, 4'b1100, 4'd9, 4'd2, 4'b0000, "pop_1100");
    drive(2'd2, 4'b0000, 4'd3, 4'd0, 4'b0001, "pop_0000");
    drive(2'd3, 4'b0000, 4'd2, 4'd0, 4'b0001, "shl_0_2");
    drive(2'd3, 4'b0010, 4'd1, 4'd4, 4'b0000, "shl_2_1");
    drive(2'd3, 4'b0000, 4'd13, 4'd0, 4'b0001, "shl_0_13");
    drive(2'd3, 4'b1001, 4'd1, 4'b0010, 4'b0010, "shl_9_1");
    drive(2'd3, 4'b0001, 4'd3, 4'b1000, 4'b0100, "shl_1_3");
    drive(2'd3, 4'b0001, 4'd4, 4'd0, 4'b0011, "shl_1_4");
    drive(2'd3, 4'b1010, 4'd0, 4'b1010, 4'b0100, "shl_a_0");
    drive(2'd3, 4'b0110, 4'd15, 4'd0, 4'b0011, "shl_6_15");
    drive(2'd0, 4'd6, 4'd7, 4'd13, 4'b1100, "add_6_7");
    wait_drain("main_seq");

    // asynchronous reset between edges, held across one rising edge
    check_now("pre_reset_nonzero", 4'd13, 4'b1100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 4'd0, 4'd0);
    @(posedge clk);
    #1;
    check_now("reset_held", 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd0, 4'd1, 4'd1, 4'd2, 4'b0000, "add_after_reset");
    wait_drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, required completion");
    $fatal(1);
  end

endmodule
